// File: rtl/l2_port_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : l2_port_arbiter_if
// Description : Bundle of I-cache, D-cache and L2 port signals shared by the
//               L2 port arbiter. The slave view belongs to the arbiter and the
//               master view to the requesters and the L2 side.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface l2_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  // I-cache side
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // D-cache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // L2 side
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  // Arbiter view
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
  );

  // Requester / L2 view
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
  );
endinterface

`default_nettype wire

// File: rtl/l2_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : l2_port_arbiter
// Description : Shares one L2 cache port between the L1 I-cache and D-cache.
//               D-cache has priority; after MAX_D_STREAK consecutive contended
//               D grants the I-cache is served. Command lines of the owner are
//               forwarded while it is served; the response pulse is steered to
//               the owner only.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module l2_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  l2_port_arbiter_if.slave        bus,
  output logic                    owner,
  output logic                    busy
);

  localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] d_streak_q, d_streak_d;
  logic                i_req, d_req;
  logic                serve_i, serve_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // Next-state and starvation-counter logic; the counter only moves on a grant.
  always_comb begin
    state_d    = state_q;
    d_streak_d = d_streak_q;
    case (state_q)
      ST_IDLE: begin
        if (d_req && i_req) begin
          if (d_streak_q == STREAK_MAX) begin
            state_d    = ST_SERVE_I;
            d_streak_d = '0;
          end else begin
            state_d    = ST_SERVE_D;
            d_streak_d = d_streak_q + STREAK_W'(1);
          end
        end else if (d_req) begin
          state_d    = ST_SERVE_D;
          d_streak_d = '0;
        end else if (i_req) begin
          state_d    = ST_SERVE_I;
          d_streak_d = '0;
        end
      end
      // A response completes the transfer even if the request drops with it;
      // a dropped request without a response is an abort.
      ST_SERVE_I: begin
        if (bus.l2_resp)  state_d = ST_RELEASE;
        else if (!i_req)  state_d = ST_IDLE;
      end
      ST_SERVE_D: begin
        if (bus.l2_resp)  state_d = ST_RELEASE;
        else if (!d_req)  state_d = ST_IDLE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and streak registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      d_streak_q <= '0;
    end else begin
      state_q    <= state_d;
      d_streak_q <= d_streak_d;
    end
  end

  assign serve_i = (state_q == ST_SERVE_I);
  assign serve_d = (state_q == ST_SERVE_D);

  // Status decoded from state only, so no request input reaches owner/busy.
  assign owner = serve_d;
  assign busy  = serve_i | serve_d;

  // L2 command mux: write beats read when the D-cache raises both.
  assign bus.l2_read  = serve_i | (serve_d & bus.d_read & ~bus.d_write);
  assign bus.l2_write = serve_d & bus.d_write;
  assign bus.l2_addr  = serve_i ? bus.i_addr : (serve_d ? bus.d_addr : '0);
  assign bus.l2_wdata = serve_d ? bus.d_wdata : '0;

  // Response steering: data is broadcast, only the pulse is gated to the owner.
  assign bus.i_resp  = serve_i & bus.l2_resp;
  assign bus.d_resp  = serve_d & bus.l2_resp;
  assign bus.i_rdata = bus.l2_rdata;
  assign bus.d_rdata = bus.l2_rdata;

endmodule

`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_l2_port_arbiter
// Description : Self-checking bench for l2_port_arbiter: a table of single
//               transactions plus contention, starvation, abort and reset
//               sequences. Grant contents are checked against a queue of
//               expected grants.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_l2_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int MAX_D  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic owner;
  logic busy;

  always #5 clk = ~clk;

  l2_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  l2_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .LINE_W       (LINE_W),
    .MAX_D_STREAK (MAX_D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .owner (owner),
    .busy  (busy)
  );

  typedef struct {
    logic              own;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;

  typedef struct {
    int                kind;   // 0 I read, 1 D read, 2 D write, 3 D read+write
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    int                lat;
    exp_t              exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic own, input logic rd, input logic wr,
                                  input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata);
    exp_t e;
    e.own = own; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata;
    return e;
  endfunction

  task automatic add_vec(input int kind, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                         input int lat, input exp_t e);
    vec_t v;
    v.kind = kind; v.addr = addr; v.wdata = wdata; v.lat = lat; v.exp = e;
    vecs.push_back(v);
  endtask

  // Scoreboard: each new grant must match the oldest expected grant.
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_prev) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL sb_unexpected_grant: got grant owner=%0d required no grant", owner);
      end else begin
        e = sb_q.pop_front();
        chk("sb_owner", owner, e.own);
        chk("sb_l2_read", bus.l2_read, e.rd);
        chk("sb_l2_write", bus.l2_write, e.wr);
        chk("sb_l2_addr", bus.l2_addr, e.addr);
        chk("sb_l2_wdata", bus.l2_wdata, e.wdata);
      end
    end
    busy_prev = busy;
  end

  task automatic drive_req(input int kind, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata);
    bus.i_read  = (kind == 0);
    bus.d_read  = (kind == 1) || (kind == 3);
    bus.d_write = (kind == 2) || (kind == 3);
    bus.i_addr  = (kind == 0) ? addr : ~addr;
    bus.d_addr  = (kind == 0) ? ~addr : addr;
    bus.d_wdata = wdata;
  endtask

  // Counts falling edges until busy is seen; ends on the first served cycle.
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 40);
    if (!busy) begin
      n_vec++;
      n_fail++;
      $display("FAIL grant_timeout: got busy=0 required busy=1 within 40 cycles");
    end
  endtask

  // From the first served cycle: hold for lat cycles, respond, then check RELEASE.
  task automatic finish_txn(input logic is_d, input logic [ADDR_W-1:0] addr, input int lat);
    logic [LINE_W-1:0] rd;
    for (int k = 0; k < lat; k++) begin
      chk("hold_addr", bus.l2_addr, addr);
      chk("hold_busy", busy, 1'b1);
      chk("hold_owner", owner, is_d);
      chk("early_resp", {bus.i_resp, bus.d_resp}, 2'b00);
      @(negedge clk);
    end
    for (int w = 0; w < LINE_W / 32; w++) rd[w*32 +: 32] = $urandom();
    bus.l2_rdata = rd;
    bus.l2_resp  = 1'b1;
    #1;
    chk("resp_i", bus.i_resp, !is_d);
    chk("resp_d", bus.d_resp, is_d);
    chk("rdata_i", bus.i_rdata, rd);
    chk("rdata_d", bus.d_rdata, rd);
    chk("resp_addr", bus.l2_addr, addr);
    @(posedge clk);
    #1;
    bus.l2_resp = 1'b0;
    if (is_d) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end else begin
      bus.i_read = 1'b0;
    end
    @(negedge clk);
    chk("rel_busy", busy, 1'b0);
    chk("rel_cmd", {bus.l2_read, bus.l2_write}, 2'b00);
    chk("rel_owner", owner, 1'b0);
    chk("rel_resp", {bus.i_resp, bus.d_resp}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int                n;
    logic [LINE_W-1:0] pat;
    logic [LINE_W-1:0] beef;
    logic [ADDR_W-1:0] ia;
    logic [ADDR_W-1:0] da;
    logic              seq [6];

    beef = {8{32'hDEADBEEF}};
    pat  = {8{32'hA5A5_5A5A}};
    seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    add_vec(0, 32'h0000_1040, {8{32'h1234_5678}}, 5, mk_exp(1'b0, 1'b1, 1'b0, 32'h0000_1040, '0));
    add_vec(2, 32'h8000_0000, beef,               3, mk_exp(1'b1, 1'b0, 1'b1, 32'h8000_0000, beef));
    add_vec(1, 32'h0000_2000, pat,                1, mk_exp(1'b1, 1'b1, 1'b0, 32'h0000_2000, pat));
    add_vec(3, 32'hABCD_0040, ~pat,               0, mk_exp(1'b1, 1'b0, 1'b1, 32'hABCD_0040, ~pat));
    add_vec(0, 32'hFFFF_FFC0, beef,               2, mk_exp(1'b0, 1'b1, 1'b0, 32'hFFFF_FFC0, '0));

    // Reset, then idle
    bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
    bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.l2_resp = 0; bus.l2_rdata = pat;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_owner", owner, 1'b0);
      chk("rst_cmd", {bus.l2_read, bus.l2_write}, 2'b00);
      chk("rst_rdata", bus.i_rdata, pat);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_l2_read", bus.l2_read, 1'b0);
      chk("idle_l2_write", bus.l2_write, 1'b0);
      chk("idle_owner", owner, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end

    // Table of isolated transactions
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive_req(vecs[i].kind, vecs[i].addr, vecs[i].wdata);
      sb_q.push_back(vecs[i].exp);
      wait_grant(n);
      chk("grant_lat", n, 2);
      finish_txn(vecs[i].kind != 0, vecs[i].addr, vecs[i].lat);
    end

    // Contention: D first, I granted 3 cycles after d_resp
    ia = 32'h0000_3000;
    da = 32'h0000_4000;
    @(posedge clk);
    #1;
    bus.i_read = 1; bus.i_addr = ia;
    bus.d_read = 1; bus.d_addr = da; bus.d_wdata = pat;
    sb_q.push_back(mk_exp(1'b1, 1'b1, 1'b0, da, pat));
    sb_q.push_back(mk_exp(1'b0, 1'b1, 1'b0, ia, '0));
    wait_grant(n);
    chk("cont_d_lat", n, 2);
    finish_txn(1'b1, da, 2);
    wait_grant(n);
    chk("cont_i_after_d", n, 2);
    finish_txn(1'b0, ia, 1);

    // Starvation bound: 4 D, then I, then D again
    ia = 32'h0000_5000;
    da = 32'h0000_6000;
    @(posedge clk);
    #1;
    bus.i_read = 1; bus.i_addr = ia;
    bus.d_read = 1; bus.d_addr = da; bus.d_wdata = beef;
    sb_q.push_back(seq[0] ? mk_exp(1'b1, 1'b1, 1'b0, da, beef) : mk_exp(1'b0, 1'b1, 1'b0, ia, '0));
    for (int k = 0; k < 6; k++) begin
      wait_grant(n);
      chk("starve_lat", n, 2);
      chk("starve_owner", owner, seq[k]);
      finish_txn(seq[k], seq[k] ? da : ia, 1);
      if (k < 5) begin
        @(posedge clk);
        #1;
        bus.d_read = 1'b1;
        sb_q.push_back(seq[k+1] ? mk_exp(1'b1, 1'b1, 1'b0, da, beef) : mk_exp(1'b0, 1'b1, 1'b0, ia, '0));
      end
    end

    // Abort: I request drops before any response
    @(posedge clk);
    #1;
    bus.i_read = 1; bus.i_addr = ia;
    sb_q.push_back(mk_exp(1'b0, 1'b1, 1'b0, ia, '0));
    wait_grant(n);
    chk("abort_lat", n, 2);
    @(posedge clk);
    #1 bus.i_read = 1'b0;
    @(negedge clk);
    chk("abort_no_resp", bus.i_resp, 1'b0);
    @(negedge clk);
    chk("abort_idle_busy", busy, 1'b0);
    chk("abort_idle_cmd", {bus.l2_read, bus.l2_write}, 2'b00);
    bus.l2_resp = 1'b1;
    #1;
    chk("abort_late_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    @(posedge clk);
    #1 bus.l2_resp = 1'b0;
    @(negedge clk);
    chk("abort_stay_idle", busy, 1'b0);

    // Reset during SERVE_D
    @(posedge clk);
    #1;
    bus.d_write = 1; bus.d_addr = da; bus.d_wdata = beef;
    sb_q.push_back(mk_exp(1'b1, 1'b0, 1'b1, da, beef));
    wait_grant(n);
    chk("rstmid_lat", n, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_owner", owner, 1'b0);
    chk("rstmid_cmd", {bus.l2_read, bus.l2_write}, 2'b00);
    chk("rstmid_addr", bus.l2_addr, '0);
    chk("rstmid_wdata", bus.l2_wdata, '0);
    bus.l2_resp = 1'b1;
    #1;
    chk("rstmid_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    @(posedge clk);
    #1;
    bus.d_write = 1'b0;
    bus.l2_resp = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_idle", busy, 1'b0);
    end

    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
